// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALUOp encodings, bubble defaults and
// the t_new countdown helper.
package id_ex_stage_pkg;

    localparam int ALUOP_W = 6;
    localparam int T_NEW_W = 2;
    localparam int REG_W   = 5;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 6'b000000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB = 6'b000001;
    localparam logic [ALUOP_W-1:0] ALUOP_OR  = 6'b000010;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL = 6'b000011;

    localparam logic [ALUOP_W-1:0] NOP_ALUOP_DEF = ALUOP_ADD;
    localparam logic [31:0]        RESET_PC_DEF  = 32'h0000_3000;

    // One stage closer to the result; saturates at zero.
    function automatic logic [T_NEW_W-1:0] t_new_dec(input logic [T_NEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd.sv
// Operand forwarding mux: picks the M result, else the W result, else the
// registered GRF value. Register $0 is never forwarded.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [REG_W-1:0]  reg_idx,
    input  logic [DATA_W-1:0] reg_val,
    input  logic [REG_W-1:0]  m_addr,
    input  logic [DATA_W-1:0] m_data,
    input  logic              m_valid,
    input  logic [REG_W-1:0]  w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_valid,
    output logic [DATA_W-1:0] fwd_val
);

    logic m_hit;
    logic w_hit;

    always_comb begin
        m_hit = m_valid && (m_addr != '0) && (m_addr == reg_idx);
        w_hit = w_valid && (w_addr != '0) && (w_addr == reg_idx);
        if (m_hit)
            fwd_val = m_data;
        else if (w_hit)
            fwd_val = w_data;
        else
            fwd_val = reg_val;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with E-stage operand forwarding feeding the ALU.
// Reset and stall load a bubble; hold freezes the whole stage.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int                  DATA_W    = 32,
    parameter logic [ALUOP_W-1:0]  NOP_ALUOP = NOP_ALUOP_DEF,
    parameter logic [DATA_W-1:0]   RESET_PC  = DATA_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               hold,
    input  logic [DATA_W-1:0]  pc_d,
    input  logic [DATA_W-1:0]  instr_d,
    input  logic [DATA_W-1:0]  rs_data_d,
    input  logic [DATA_W-1:0]  rt_data_d,
    input  logic [DATA_W-1:0]  ext_imm_d,
    input  logic [ALUOP_W-1:0] alu_op_d,
    input  logic               alu_src_d,
    input  logic               reg_write_d,
    input  logic [REG_W-1:0]   a3_d,
    input  logic               mem_write_d,
    input  logic               mem_to_reg_d,
    input  logic [T_NEW_W-1:0] t_new_d,
    input  logic [REG_W-1:0]   fwd_m_addr,
    input  logic [DATA_W-1:0]  fwd_m_data,
    input  logic               fwd_m_valid,
    input  logic [REG_W-1:0]   fwd_w_addr,
    input  logic [DATA_W-1:0]  fwd_w_data,
    input  logic               fwd_w_valid,
    output logic [DATA_W-1:0]  alu_a_e,
    output logic [DATA_W-1:0]  alu_b_e,
    output logic [4:0]         alu_s_e,
    output logic [ALUOP_W-1:0] alu_op_e,
    output logic [DATA_W-1:0]  rt_fwd_e,
    output logic [DATA_W-1:0]  pc_e,
    output logic [DATA_W-1:0]  instr_e,
    output logic [DATA_W-1:0]  ext_imm_e,
    output logic               reg_write_e,
    output logic [REG_W-1:0]   a3_e,
    output logic               mem_write_e,
    output logic               mem_to_reg_e,
    output logic [T_NEW_W-1:0] t_new_e
);

    logic [DATA_W-1:0] rs_data_e;
    logic [DATA_W-1:0] rt_data_e;
    logic              alu_src_e;
    logic              load_bubble;
    logic              capture;

    // Reset wins over hold; stall only matters when the stage is not frozen.
    assign load_bubble = reset || (!hold && stall);
    assign capture     = !reset && !hold && !stall;

    always_ff @(posedge clk) begin
        if (load_bubble) begin
            pc_e         <= RESET_PC;
            instr_e      <= '0;
            rs_data_e    <= '0;
            rt_data_e    <= '0;
            ext_imm_e    <= '0;
            alu_op_e     <= NOP_ALUOP;
            alu_src_e    <= 1'b0;
            reg_write_e  <= 1'b0;
            a3_e         <= '0;
            mem_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            t_new_e      <= '0;
        end else if (capture) begin
            pc_e         <= pc_d;
            instr_e      <= instr_d;
            rs_data_e    <= rs_data_d;
            rt_data_e    <= rt_data_d;
            ext_imm_e    <= ext_imm_d;
            alu_op_e     <= alu_op_d;
            alu_src_e    <= alu_src_d;
            reg_write_e  <= reg_write_d;
            a3_e         <= a3_d;
            mem_write_e  <= mem_write_d;
            mem_to_reg_e <= mem_to_reg_d;
            t_new_e      <= t_new_dec(t_new_d);
        end
    end

    // E stage: combinational forwarding, zero cycles to the ALU.
    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs (
        .reg_idx (instr_e[25:21]),
        .reg_val (rs_data_e),
        .m_addr  (fwd_m_addr),
        .m_data  (fwd_m_data),
        .m_valid (fwd_m_valid),
        .w_addr  (fwd_w_addr),
        .w_data  (fwd_w_data),
        .w_valid (fwd_w_valid),
        .fwd_val (alu_a_e)
    );

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rt (
        .reg_idx (instr_e[20:16]),
        .reg_val (rt_data_e),
        .m_addr  (fwd_m_addr),
        .m_data  (fwd_m_data),
        .m_valid (fwd_m_valid),
        .w_addr  (fwd_w_addr),
        .w_data  (fwd_w_data),
        .w_valid (fwd_w_valid),
        .fwd_val (rt_fwd_e)
    );

    assign alu_b_e = alu_src_e ? ext_imm_e : rt_fwd_e;
    assign alu_s_e = instr_e[10:6];

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the E stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, hold;
    logic [31:0] pc_d, instr_d, rs_data_d, rt_data_d, ext_imm_d;
    logic [5:0]  alu_op_d;
    logic        alu_src_d, reg_write_d, mem_write_d, mem_to_reg_d;
    logic [4:0]  a3_d;
    logic [1:0]  t_new_d;
    logic [4:0]  fwd_m_addr, fwd_w_addr;
    logic [31:0] fwd_m_data, fwd_w_data;
    logic        fwd_m_valid, fwd_w_valid;
    logic [31:0] alu_a_e, alu_b_e, rt_fwd_e, pc_e, instr_e, ext_imm_e;
    logic [4:0]  alu_s_e, a3_e;
    logic [5:0]  alu_op_e;
    logic        reg_write_e, mem_write_e, mem_to_reg_e;
    logic [1:0]  t_new_e;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .hold(hold),
        .pc_d(pc_d), .instr_d(instr_d), .rs_data_d(rs_data_d), .rt_data_d(rt_data_d),
        .ext_imm_d(ext_imm_d), .alu_op_d(alu_op_d), .alu_src_d(alu_src_d),
        .reg_write_d(reg_write_d), .a3_d(a3_d), .mem_write_d(mem_write_d),
        .mem_to_reg_d(mem_to_reg_d), .t_new_d(t_new_d),
        .fwd_m_addr(fwd_m_addr), .fwd_m_data(fwd_m_data), .fwd_m_valid(fwd_m_valid),
        .fwd_w_addr(fwd_w_addr), .fwd_w_data(fwd_w_data), .fwd_w_valid(fwd_w_valid),
        .alu_a_e(alu_a_e), .alu_b_e(alu_b_e), .alu_s_e(alu_s_e), .alu_op_e(alu_op_e),
        .rt_fwd_e(rt_fwd_e), .pc_e(pc_e), .instr_e(instr_e), .ext_imm_e(ext_imm_e),
        .reg_write_e(reg_write_e), .a3_e(a3_e), .mem_write_e(mem_write_e),
        .mem_to_reg_e(mem_to_reg_e), .t_new_e(t_new_e)
    );

    // Model of what the E stage holds: one record of the last accepted ID slot.
    typedef struct {
        logic [31:0] pc, instr, rs, rt, imm;
        logic [5:0]  op;
        logic        src, rw, mw, mr;
        logic [4:0]  a3;
        logic [1:0]  tn;
    } slot_t;

    slot_t mdl;
    bit    model_ok = 0;

    function automatic slot_t bubble_slot();
        slot_t s;
        s.pc = 32'h0000_3000; s.instr = 0; s.rs = 0; s.rt = 0; s.imm = 0;
        s.op = 6'd0; s.src = 0; s.rw = 0; s.mw = 0; s.mr = 0; s.a3 = 0; s.tn = 0;
        return s;
    endfunction

    function automatic slot_t id_slot();
        slot_t s;
        s.pc = pc_d; s.instr = instr_d; s.rs = rs_data_d; s.rt = rt_data_d;
        s.imm = ext_imm_d; s.op = alu_op_d; s.src = alu_src_d; s.rw = reg_write_d;
        s.mw = mem_write_d; s.mr = mem_to_reg_d; s.a3 = a3_d;
        s.tn = (t_new_d > 0) ? t_new_d - 2'd1 : 2'd0;
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mdl = bubble_slot();
            model_ok = 1;
        end else if (hold) begin
            mdl = mdl;
        end else if (stall) begin
            mdl = bubble_slot();
        end else begin
            mdl = id_slot();
        end
    end

    // Value an operand register reads as in E, given what M and W hold now.
    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] grf);
        if (idx == 0) return grf;
        if (fwd_m_valid && fwd_m_addr == idx) return fwd_m_data;
        if (fwd_w_valid && fwd_w_addr == idx) return fwd_w_data;
        return grf;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            logic [31:0] a, rt;
            a  = operand(mdl.instr[25:21], mdl.rs);
            rt = operand(mdl.instr[20:16], mdl.rt);
            check("alu_a_e", alu_a_e, a);
            check("rt_fwd_e", rt_fwd_e, rt);
            check("alu_b_e", alu_b_e, mdl.src ? mdl.imm : rt);
            check("alu_s_e", 32'(alu_s_e), 32'((mdl.instr >> 6) & 32'h1f));
            check("alu_op_e", 32'(alu_op_e), 32'(mdl.op));
            check("pc_e", pc_e, mdl.pc);
            check("instr_e", instr_e, mdl.instr);
            check("ext_imm_e", ext_imm_e, mdl.imm);
            check("reg_write_e", 32'(reg_write_e), 32'(mdl.rw));
            check("a3_e", 32'(a3_e), 32'(mdl.a3));
            check("mem_write_e", 32'(mem_write_e), 32'(mdl.mw));
            check("mem_to_reg_e", 32'(mem_to_reg_e), 32'(mdl.mr));
            check("t_new_e", 32'(t_new_e), 32'(mdl.tn));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_id();
        pc_d = $urandom; rs_data_d = $urandom; rt_data_d = $urandom; ext_imm_d = $urandom;
        instr_d = $urandom;
        instr_d[25:21] = 5'($urandom_range(0, 3));
        instr_d[20:16] = 5'($urandom_range(0, 3));
        alu_op_d = 6'($urandom); alu_src_d = 1'($urandom); reg_write_d = 1'($urandom);
        a3_d = 5'($urandom); mem_write_d = 1'($urandom); mem_to_reg_d = 1'($urandom);
        t_new_d = 2'($urandom);
    endtask

    task automatic rand_fwd();
        fwd_m_addr = 5'($urandom_range(0, 3)); fwd_m_data = $urandom; fwd_m_valid = 1'($urandom);
        fwd_w_addr = 5'($urandom_range(0, 3)); fwd_w_data = $urandom; fwd_w_valid = 1'($urandom);
    endtask

    task automatic clear_id();
        pc_d = 32'h3000; instr_d = 0; rs_data_d = 0; rt_data_d = 0; ext_imm_d = 0;
        alu_op_d = 0; alu_src_d = 0; reg_write_d = 0; a3_d = 0; mem_write_d = 0;
        mem_to_reg_d = 0; t_new_d = 0;
    endtask

    task automatic no_fwd();
        fwd_m_addr = 0; fwd_m_data = 0; fwd_m_valid = 0;
        fwd_w_addr = 0; fwd_w_data = 0; fwd_w_valid = 0;
    endtask

    initial begin
        reset = 1; stall = 0; hold = 0;
        rand_id();
        no_fwd();

        // Reset for two cycles with random ID fields.
        tick(); rand_id(); tick(); #3;
        check("rst_alu_op", 32'(alu_op_e), 32'h0);
        check("rst_reg_write", 32'(reg_write_e), 32'h0);
        check("rst_pc", pc_e, 32'h0000_3000);
        check("rst_instr", instr_e, 32'h0);
        check("rst_alu_a", alu_a_e, 32'h0);

        // addu $3,$1,$2 with no forwarding.
        reset = 0; clear_id();
        instr_d = 32'h0022_1821; rs_data_d = 5; rt_data_d = 7; a3_d = 3; reg_write_d = 1;
        tick(); #3;
        check("addu_a", alu_a_e, 32'd5);
        check("addu_b", alu_b_e, 32'd7);
        check("addu_a3", 32'(a3_e), 32'd3);

        // Forward priority on rs = $4.
        clear_id(); instr_d = 32'h0080_0000; rs_data_d = 32'h1234;
        tick();
        fwd_m_addr = 4; fwd_m_data = 32'hAAAA; fwd_m_valid = 1;
        fwd_w_addr = 4; fwd_w_data = 32'hBBBB; fwd_w_valid = 1;
        #3 check("fwd_m_first", alu_a_e, 32'hAAAA);
        tick(); fwd_m_valid = 0;
        #3 check("fwd_w_second", alu_a_e, 32'hBBBB);
        tick(); fwd_w_valid = 0;
        #3 check("fwd_none", alu_a_e, 32'h1234);

        // $0 is never forwarded.
        clear_id(); instr_d = 32'h0020_0000; rt_data_d = 0;
        fwd_m_addr = 0; fwd_m_data = 32'hFFFF_FFFF; fwd_m_valid = 1;
        tick(); #3;
        check("zero_guard", rt_fwd_e, 32'h0);
        no_fwd();

        // Stall with a lw in ID, then let it through.
        clear_id(); pc_d = 32'h3010; instr_d = 32'h8C25_0010; rs_data_d = 32'h100;
        ext_imm_d = 32'h10; alu_src_d = 1; reg_write_d = 1; mem_to_reg_d = 1;
        a3_d = 5; t_new_d = 2; stall = 1;
        tick(); #3;
        check("stall_instr", instr_e, 32'h0);
        check("stall_pc", pc_e, 32'h0000_3000);
        check("stall_mem_to_reg", 32'(mem_to_reg_e), 32'h0);
        stall = 0;
        tick(); #3;
        check("lw_instr", instr_e, 32'h8C25_0010);
        check("lw_t_new", 32'(t_new_e), 32'd1);
        check("lw_alu_b", alu_b_e, 32'h10);
        t_new_d = 0;
        tick(); #3;
        check("t_new_zero", 32'(t_new_e), 32'd0);

        // Hold freezes E while ID changes.
        clear_id(); pc_d = 32'h3040; instr_d = 32'h0085_1020;
        tick(); hold = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id(); tick(); #3;
            check("hold_instr", instr_e, 32'h0085_1020);
            check("hold_pc", pc_e, 32'h3040);
        end
        stall = 1; rand_id(); tick(); #3;
        check("hold_stall_instr", instr_e, 32'h0085_1020);
        reset = 1; tick(); #3;
        check("hold_reset_instr", instr_e, 32'h0);
        check("hold_reset_pc", pc_e, 32'h0000_3000);
        reset = 0; stall = 0; hold = 0;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 12);
            hold  = ($urandom_range(0, 99) < 12);
            rand_id();
            rand_fwd();
            tick();
        end

        reset = 0; stall = 0; hold = 0;
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
